// File: rtl/word_stacker.sv
// word_stacker: packs a stream of WORD_W-bit words (first word in the MSBs) into BLK_W-bit blocks
// queued in a 2-entry block FIFO. Define WORD_STACKER_FLUSH_EN to add the partial-block flush input.
module word_stacker #(
    parameter  int WORD_W    = 32,
    parameter  int NUM_WORDS = 4,
    localparam int BLK_W     = WORD_W * NUM_WORDS,
    localparam int CNT_W     = $clog2(NUM_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              enable_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WORD_W-1:0] word_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [BLK_W-1:0]  block_o,
    output logic [CNT_W-1:0]  fill_o,
`ifdef WORD_STACKER_FLUSH_EN
    input  logic              flush_i,
`endif
    output logic [1:0]        level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [BLK_W-1:0] r_fill;
    logic [BLK_W-1:0] r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_level;
    logic             r_flush_pend;

    logic             w_last;
    logic             w_acc;
    logic             w_pop;
    logic             w_natural_push;
    logic             w_flush_push;
    logic             w_flush_set;
    logic             w_push;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [BLK_W-1:0] w_assembled;
    logic [BLK_W-1:0] w_push_data;

    // Ready never looks at ready_i: a full partial block only stalls when both FIFO slots are taken.
    assign w_last    = (r_cnt == CNT_LAST);
    assign ready_o   = enable_i & ~r_flush_pend & ~(w_last & (r_level == 2'd2));
    assign w_acc     = valid_i & ready_o;
    assign valid_o   = enable_i & (r_level != 2'd0);
    assign w_pop     = valid_o & ready_i;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    assign block_o = (r_level != 2'd0) ? r_mem[r_rd_ptr] : '0;
    assign fill_o  = r_cnt;
    assign level_o = r_level;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
            assign w_assembled[BLK_W-1-gi*WORD_W -: WORD_W] =
                (w_acc && (r_cnt == CNT_W'(gi))) ? word_i : r_fill[BLK_W-1-gi*WORD_W -: WORD_W];
        end
    endgenerate

`ifdef WORD_STACKER_FLUSH_EN
    logic w_cnt_after_nz;

    // A flush that lands on the word completing a block leaves nothing partial behind.
    assign w_cnt_after_nz = w_acc ? (w_cnt_inc != '0) : (r_cnt != '0);
    assign w_flush_set    = enable_i & flush_i & ~r_flush_pend & w_cnt_after_nz;
    assign w_flush_push   = enable_i & r_flush_pend & (r_level != 2'd2);
`else
    assign w_flush_set    = 1'b0;
    assign w_flush_push   = 1'b0;
`endif

    assign w_natural_push = w_acc & w_last;
    assign w_push         = w_natural_push | w_flush_push;
    assign w_push_data    = w_natural_push ? w_assembled : r_fill;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt        <= '0;
            r_fill       <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_level      <= 2'd0;
            r_flush_pend <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else if (enable_i) begin
            if (w_acc) begin
                r_cnt  <= w_cnt_inc;
                r_fill <= w_last ? '0 : w_assembled;
            end else if (w_flush_push) begin
                r_cnt  <= '0;
                r_fill <= '0;
            end

            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_level <= r_level + {1'b0, w_push} - {1'b0, w_pop};

            if (w_flush_push) begin
                r_flush_pend <= 1'b0;
            end else if (w_flush_set) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_stacker.sv
// tb_word_stacker: directed scenarios plus randomized traffic against a queue-based model;
// expected blocks go to a scoreboard that an independent monitor drains on every output handshake.
module tb_word_stacker;

    localparam int NW = 4;
    localparam int WW = 32;
    localparam int BW = 128;

    logic          clk      = 1'b0;
    logic          rst_i    = 1'b1;
    logic          clr_i    = 1'b0;
    logic          enable_i = 1'b1;
    logic          valid_i  = 1'b0;
    logic          ready_i  = 1'b0;
    logic          flush_i  = 1'b0;
    logic [WW-1:0] word_i   = '0;
    logic          ready_o;
    logic          valid_o;
    logic [BW-1:0] block_o;
    logic [1:0]    fill_o;
    logic [1:0]    level_o;

    int checks   = 0;
    int failures = 0;

    logic [BW-1:0] exp_q  [$];
    logic [BW-1:0] mfifo  [$];
    logic [WW-1:0] part_q [$];
    bit            pend = 1'b0;

    always #5 clk = ~clk;

    word_stacker dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .clr_i    (clr_i),
        .enable_i (enable_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .word_i   (word_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .block_o  (block_o),
        .fill_o   (fill_o),
`ifdef WORD_STACKER_FLUSH_EN
        .flush_i  (flush_i),
`endif
        .level_o  (level_o)
    );

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Words in arrival order, first word most significant, missing words zero.
    function automatic logic [BW-1:0] pack_part();
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < NW; k++) begin
            b = (b << WW) | ((k < part_q.size()) ? BW'(part_q[k]) : BW'(0));
        end
        return b;
    endfunction

    task automatic push_blk(input logic [BW-1:0] b);
        mfifo.push_back(b);
        exp_q.push_back(b);
        $display("push block %h (queued %0d)", b, mfifo.size());
    endtask

    // Reference model: partial block and FIFO as queues, advanced once per clock.
    always @(negedge clk) begin : model
        logic          er;
        logic          ev;
        logic          acc;
        logic          pop;
        logic [BW-1:0] head;
        if (rst_i || clr_i) begin
            part_q.delete();
            mfifo.delete();
            exp_q.delete();
            pend = 1'b0;
        end else begin
            er   = enable_i && !pend && !(part_q.size() == NW - 1 && mfifo.size() == 2);
            ev   = enable_i && (mfifo.size() != 0);
            head = (mfifo.size() != 0) ? mfifo[0] : '0;
            chk("ready_o", BW'(ready_o), BW'(er));
            chk("valid_o", BW'(valid_o), BW'(ev));
            chk("fill_o",  BW'(fill_o),  BW'(part_q.size()));
            chk("level_o", BW'(level_o), BW'(mfifo.size()));
            chk("head",    block_o,      head);
            if (enable_i) begin
                acc = valid_i && er;
                pop = ev && ready_i;
                if (pend && mfifo.size() < 2) begin
                    push_blk(pack_part());
                    part_q.delete();
                    pend = 1'b0;
                end else if (acc) begin
                    part_q.push_back(word_i);
                    if (part_q.size() == NW) begin
                        push_blk(pack_part());
                        part_q.delete();
                    end
                end
`ifdef WORD_STACKER_FLUSH_EN
                if (flush_i && !pend && part_q.size() != 0) pend = 1'b1;
`endif
                if (pop) void'(mfifo.pop_front());
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [BW-1:0] e;
        if (!rst_i && !clr_i && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL block_unexpected act=%h exp=none t=%0t", block_o, $time);
            end else begin
                e = exp_q.pop_front();
                chk("block_data", block_o, e);
                $display("pop block %h", block_o);
            end
        end
    end

    task automatic cyc(input logic v, input logic [WW-1:0] w, input logic r,
                       input logic en, input logic cl, input logic fl);
        @(posedge clk);
        #1;
        valid_i  = v;
        word_i   = w;
        ready_i  = r;
        enable_i = en;
        clr_i    = cl;
        flush_i  = fl;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int thr;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", BW'(valid_o), BW'(0));
        chk("rst_block", block_o, BW'(0));
        chk("rst_fill",  BW'(fill_o), BW'(0));
        chk("rst_level", BW'(level_o), BW'(0));
        chk("rst_ready", BW'(ready_o), BW'(1));

        // 1: four words back to back, block visible one cycle after the last
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hA0 + i, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_valid", BW'(valid_o), BW'(1));
        chk("t1_block", block_o, 128'h000000A0_000000A1_000000A2_000000A3);
        drain(2);

        // 2: output stalled, twelfth word must wait for the first pop
        for (int i = 0; i < 11; i++) cyc(1'b1, 32'hC0 + i, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hCB, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_level2", BW'(level_o), BW'(2));
        chk("t2_stall",  BW'(ready_o), BW'(0));
        cyc(1'b1, 32'hCB, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_stall_hold", BW'(ready_o), BW'(0));
        cyc(1'b1, 32'hCB, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_pop_cycle_ready", BW'(ready_o), BW'(0));
        chk("t2_first_block", block_o, 128'h000000C0_000000C1_000000C2_000000C3);
        cyc(1'b1, 32'hCB, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_after_pop_ready", BW'(ready_o), BW'(1));
        drain(5);

        // 3: enable low mid-block with a block queued
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hE0 + i, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hD0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hD1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'hDEAD0000 + i, 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk("t3_valid", BW'(valid_o), BW'(0));
            chk("t3_ready", BW'(ready_o), BW'(0));
            chk("t3_fill",  BW'(fill_o),  BW'(2));
        end
        cyc(1'b1, 32'hD2, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hD3, 1'b1, 1'b1, 1'b0, 1'b0);
        drain(4);

        // 4: clear with fill 3 and one block queued
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'hF0 + i, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_fill",  BW'(fill_o),  BW'(0));
        chk("t4_level", BW'(level_o), BW'(0));
        chk("t4_valid", BW'(valid_o), BW'(0));
        chk("t4_block", block_o, BW'(0));

        // 5: push and pop in the same cycle at level 1
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'h50 + i, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h57, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_old_first", block_o, 128'h00000050_00000051_00000052_00000053);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_level", BW'(level_o), BW'(1));
        chk("t5_new_head", block_o, 128'h00000054_00000055_00000056_00000057);
        drain(3);

`ifdef WORD_STACKER_FLUSH_EN
        // 6: flush of a two-word partial block, then a flush with nothing held
        cyc(1'b1, 32'hB0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hB1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_pend_ready", BW'(ready_o), BW'(0));
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_valid", BW'(valid_o), BW'(1));
        chk("t6_block", block_o, 128'h000000B0_000000B1_00000000_00000000);
        drain(2);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        drain(2);
        @(negedge clk);
        chk("t6_empty_flush_level", BW'(level_o), BW'(0));
        chk("t6_empty_flush_ready", BW'(ready_o), BW'(1));
`endif

        // Randomized traffic, alternating light and heavy output back-pressure
        for (int c = 0; c < 3000; c++) begin
            thr = ((c / 500) % 2 == 1) ? 8 : 3;
            @(posedge clk);
            #1;
            clr_i    = ($urandom_range(0, 199) == 0);
            enable_i = ($urandom_range(0, 19) != 0);
            valid_i  = ($urandom_range(0, 9) < 7);
            word_i   = $urandom;
            ready_i  = clr_i ? 1'b0 : ($urandom_range(0, 9) < thr);
`ifdef WORD_STACKER_FLUSH_EN
            flush_i  = ($urandom_range(0, 19) == 0);
`endif
        end
        drain(10);
        @(negedge clk);
        chk("scoreboard_drained", BW'(exp_q.size()), BW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
